pwm_gen: RTL and testbench

PWM_GEN -- requirements
Module: pwm_gen

---
 rtl/pwm_gen.sv | 90 +++++++++
 tb/tb_pwm_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// PWM generator: compares an external free-running 8-bit count against a duty
// threshold that only changes at period starts. Optional PWM_WRAPCNT_EN adds a period counter.
module pwm_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  value,
   input  logic [7:0]  duty_in,
   input  logic        duty_valid,
   output logic        duty_ready,
   output logic        pwm_out,
`ifdef PWM_WRAPCNT_EN
   output logic        period_pulse,
   output logic [15:0] wrap_cnt
`else
   output logic        period_pulse
`endif
);

   // state   | meaning
   // IDLE    | no duty waiting; duty_in accepted
   // PENDING | a duty is held, applied at the next period start
   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_prev_value;
   logic [7:0] r_shadow;
   logic [7:0] r_pending;
   logic       r_pwm;
   logic       r_pulse;
   logic       w_period_start;
   logic       w_xfer;
   logic       w_apply;
   logic [7:0] w_duty_eff;

   // A held-at-zero count only starts one period; prev_value makes it edge-like.
   assign w_period_start = (value == 8'h00) && (r_prev_value != 8'h00);
   assign duty_ready     = (r_state == IDLE);
   assign w_xfer         = duty_valid && duty_ready;
   assign w_apply        = w_period_start && (r_state == PENDING);
   assign w_duty_eff     = w_apply ? r_pending : r_shadow;
   assign pwm_out        = r_pwm;
   assign period_pulse   = r_pulse;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_xfer) w_state_nxt = PENDING;
         PENDING: if (w_period_start) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_shadow     <= 8'h00;
         r_pending    <= 8'h00;
         r_prev_value <= 8'hFF;
         r_pwm        <= 1'b0;
         r_pulse      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_prev_value <= value;
         r_pwm        <= (value < w_duty_eff);
         r_pulse      <= w_period_start;
         if (w_xfer) begin
            r_pending <= duty_in;
         end
         if (w_apply) begin
            r_shadow <= r_pending;
         end
      end
   end

`ifdef PWM_WRAPCNT_EN
   logic [15:0] r_wrap_cnt;

   assign wrap_cnt = r_wrap_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrap_cnt <= 16'h0000;
      end else if (w_period_start) begin
         r_wrap_cnt <= r_wrap_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: fixed vector table, directed period scenarios and a
// randomized run against a period-level reference model.
module tb_pwm_gen;

   logic        clk;
   logic        reset;
   logic [7:0]  value;
   logic [7:0]  duty_in;
   logic        duty_valid;
   logic        duty_ready;
   logic        pwm_out;
   logic        period_pulse;
`ifdef PWM_WRAPCNT_EN
   logic [15:0] wrap_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pwm_gen dut (
      .clk          (clk),
      .reset        (reset),
      .value        (value),
      .duty_in      (duty_in),
      .duty_valid   (duty_valid),
      .duty_ready   (duty_ready),
      .pwm_out      (pwm_out),
`ifdef PWM_WRAPCNT_EN
      .period_pulse (period_pulse),
      .wrap_cnt     (wrap_cnt)
`else
      .period_pulse (period_pulse)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: which duty governs the current period, and an optional
   // duty waiting for the next one.
   logic [7:0]  m_prev;
   logic [7:0]  m_active;
   logic        m_has_next;
   logic [7:0]  m_next;
   logic        m_pwm;
   logic        m_pulse;
   logic [15:0] m_periods;

   int hi_cnt;
   int pulse_cnt;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev     = 8'hFF;
      m_active   = 8'h00;
      m_has_next = 1'b0;
      m_next     = 8'h00;
      m_pwm      = 1'b0;
      m_pulse    = 1'b0;
      m_periods  = 16'h0000;
   endtask

   // One clock with model checking of all outputs.
   task automatic step(input logic [7:0] v, input logic [7:0] d, input logic dv, input logic rst);
      bit new_period;
      value = v; duty_in = d; duty_valid = dv; reset = rst;
      #1;
      chk("duty_ready", {15'd0, duty_ready}, {15'd0, !m_has_next});
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         new_period = (v == 8'd0) && (m_prev != 8'd0);
         if (new_period && m_has_next) begin
            m_active   = m_next;
            m_has_next = 1'b0;
            m_pwm      = (v < m_active);
         end else begin
            m_pwm = (v < m_active);
            if (!m_has_next && dv) begin
               m_next     = d;
               m_has_next = 1'b1;
            end
         end
         m_pulse = new_period;
         if (new_period) m_periods = m_periods + 16'd1;
         m_prev = v;
      end
      #1;
      chk("pwm_out", {15'd0, pwm_out}, {15'd0, m_pwm});
      chk("period_pulse", {15'd0, period_pulse}, {15'd0, m_pulse});
`ifdef PWM_WRAPCNT_EN
      chk("wrap_cnt", wrap_cnt, m_periods);
`endif
      if (pwm_out) hi_cnt++;
      if (period_pulse) pulse_cnt++;
   endtask

   task automatic do_reset();
      value = 8'h00; duty_in = 8'h00; duty_valid = 1'b0; reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_pwm", {15'd0, pwm_out}, 16'd0);
      chk("rst_pulse", {15'd0, period_pulse}, 16'd0);
`ifdef PWM_WRAPCNT_EN
      chk("rst_wrap", wrap_cnt, 16'd0);
`endif
      reset = 1'b0;
      #1;
      chk("rst_ready", {15'd0, duty_ready}, 16'd1);
      model_reset();
   endtask

   // Count values lo..hi in order, optionally offering a duty throughout.
   task automatic run(input int lo, input int hi, input logic [7:0] d, input logic dv);
      for (int i = lo; i <= hi; i++) step(8'(i), d, dv, 1'b0);
   endtask

   typedef struct {
      logic [7:0] value;
      logic [7:0] duty;
      logic       valid;
      logic       exp_ready;
      logic       exp_pwm;
      logic       exp_pulse;
   } vec_t;

   vec_t vecs[12];

   logic [7:0] v_cur;

   initial begin
      vecs[0]  = '{8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{8'hFF, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{8'h00, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

      hi_cnt = 0; pulse_cnt = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         value = vecs[i].value; duty_in = vecs[i].duty; duty_valid = vecs[i].valid;
         #1;
         chk($sformatf("vec%0d_ready", i), {15'd0, duty_ready}, {15'd0, vecs[i].exp_ready});
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_pwm", i), {15'd0, pwm_out}, {15'd0, vecs[i].exp_pwm});
         chk($sformatf("vec%0d_pulse", i), {15'd0, period_pulse}, {15'd0, vecs[i].exp_pulse});
      end

      // No duty written: two periods, two pulses, pwm never high.
      do_reset();
      hi_cnt = 0; pulse_cnt = 0;
      run(0, 255, 8'h00, 1'b0);
      run(0, 255, 8'h00, 1'b0);
      chk("idle_hi", 16'(hi_cnt), 16'd0);
      chk("idle_pulses", 16'(pulse_cnt), 16'd2);

      // Duty 0x40 written mid-period applies from the wrap: 64 high counts.
      run(0, 8'h7F, 8'h00, 1'b0);
      step(8'h80, 8'h40, 1'b1, 1'b0);
      hi_cnt = 0;
      run(8'h81, 255, 8'h00, 1'b0);
      chk("d40_before_wrap", 16'(hi_cnt), 16'd0);
      hi_cnt = 0;
      run(0, 255, 8'h00, 1'b0);
      chk("d40_hi", 16'(hi_cnt), 16'd64);

      // 0xFF offered then 0x10 while pending: only 0xFF is applied.
      run(0, 8'h0F, 8'h00, 1'b0);
      run(8'h10, 8'h1F, 8'hFF, 1'b1);
      run(8'h20, 8'hEF, 8'h10, 1'b1);
      run(8'hF0, 255, 8'h00, 1'b0);
      hi_cnt = 0;
      run(0, 255, 8'h00, 1'b0);
      chk("dff_hi", 16'(hi_cnt), 16'd255);

      // Transfer on the period-start cycle: old duty for this period, 0x20 next.
      hi_cnt = 0;
      step(8'h00, 8'h20, 1'b1, 1'b0);
      run(1, 255, 8'h00, 1'b0);
      chk("coincide_old", 16'(hi_cnt), 16'd255);
      hi_cnt = 0;
      run(0, 255, 8'h00, 1'b0);
      chk("coincide_new", 16'(hi_cnt), 16'd32);

      // Upstream counter reset at 0x55, then held at zero.
      run(0, 8'h55, 8'h00, 1'b0);
      pulse_cnt = 0;
      for (int i = 0; i < 6; i++) step(8'h00, 8'h00, 1'b0, 1'b0);
      chk("hold0_pulses", 16'(pulse_cnt), 16'd1);

      // Duty zero: never high.
      run(1, 8'h30, 8'h00, 1'b1);
      run(8'h31, 255, 8'h00, 1'b0);
      hi_cnt = 0;
      run(0, 255, 8'h00, 1'b0);
      chk("d00_hi", 16'(hi_cnt), 16'd0);

`ifdef PWM_WRAPCNT_EN
      do_reset();
      for (int p = 0; p < 3; p++) run(0, 255, 8'h00, 1'b0);
      chk("wrap3", wrap_cnt, 16'd3);
`endif

      // Randomized: mostly counting, with jumps, early wraps and rare resets.
      v_cur = 8'h00;
      for (int i = 0; i < 6000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3) v_cur = 8'h00;
         else if (r < 5) v_cur = 8'($urandom);
         else v_cur = v_cur + 8'd1;
         step(v_cur, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
